// File: rtl/tx_sample_feeder_pkg.sv
// tx_sample_feeder_pkg: shared types for the I2S Tx sample feeder
//   frame_size_t / OP_t : operating params (only frame_size is consumed here)
//   chan_t              : sample channel tag
//   feed_state_t        : feeder FSM states
package tx_sample_feeder_pkg;
  typedef enum logic {f16bits, f32bits} frame_size_t;
  typedef struct packed {
    frame_size_t frame_size;
  } OP_t;
  typedef enum logic {CH_L, CH_R} chan_t;
  typedef enum logic {EXP_L, EXP_R} feed_state_t;
endpackage

// File: rtl/tx_sample_feeder_pair_buf.sv
// pair_buf: 2-entry register FIFO, loaded a whole pair at a time, drained one word per pop
//   wclk, rst_ : clock, async active-low reset
//   push, a, b : load {a, b} (only when empty)
//   pop        : drop head (only when cnt != 0)
//   cnt, head  : occupancy and head word
module pair_buf #(
  parameter int WIDTH = 32
) (
  input  logic             wclk,
  input  logic             rst_,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       cnt,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    e0_d  = push ? a : pop ? e1_q : e0_q;
    e1_d  = push ? b : e1_q;
    cnt_d = push ? 2'd2 : pop ? cnt_q - 2'd1 : cnt_q;
  end
  always_ff @(posedge wclk or negedge rst_)
    if (!rst_) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  assign cnt  = cnt_q;
  assign head = e0_q;
endmodule

// File: rtl/tx_sample_feeder.sv
// tx_sample_feeder: pairs L/R host samples, formats them and writes whole pairs to the Tx FIFO
//   wclk, rst_                : write clock, async active-low reset
//   en, OP                    : enable, frame size
//   s_valid/s_ready/s_data/s_chan : host sample stream
//   fifo_full, wr_en, din     : Tx FIFO write port
//   err_order, err_clr        : sticky out-of-order flag and its clear
//   pair_cnt                  : pairs enqueued (wraps)
module tx_sample_feeder
  import tx_sample_feeder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             wclk,
  input  logic             rst_,
  input  logic             en,
  input  OP_t              OP,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  chan_t            s_chan,
  input  logic             fifo_full,
  output logic             wr_en,
  output logic [WIDTH-1:0] din,
  output logic             err_order,
  input  logic             err_clr,
  output logic [CNT_W-1:0] pair_cnt
);
  feed_state_t state_q, state_d;
  frame_size_t fs_pair_q, fs_pair_d;
  logic lpend_v_q, lpend_v_d, err_order_q, err_order_d;
  logic [WIDTH-1:0] lpend_q, lpend_d;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
  logic [1:0] cnt;
  logic xfer, bad, good, push;
  function automatic logic [WIDTH-1:0] fmt(input logic [WIDTH-1:0] d, input frame_size_t fs);
    return fs == f16bits ? {{(WIDTH-16){1'b0}}, d[15:0]} : d;
  endfunction
  always_comb begin
    s_ready     = en && (state_q == EXP_L ? !lpend_v_q : cnt == 2'd0);
    xfer        = s_valid && s_ready;
    // a wrong-channel sample is consumed but dropped; the FSM stays put
    bad         = xfer && ((s_chan == CH_R) != (state_q == EXP_R));
    good        = xfer && !bad;
    push        = good && state_q == EXP_R;
    state_d     = !en ? EXP_L : good ? (state_q == EXP_L ? EXP_R : EXP_L) : state_q;
    lpend_v_d   = en && (good ? state_q == EXP_L : lpend_v_q);
    lpend_d     = good && state_q == EXP_L ? fmt(s_data, OP.frame_size) : lpend_q;
    // the R half reuses the L half's frame size so a pair is never split
    fs_pair_d   = good && state_q == EXP_L ? OP.frame_size : fs_pair_q;
    err_order_d = bad || (err_order_q && !err_clr);
    pair_cnt_d  = pair_cnt_q + {{(CNT_W-1){1'b0}}, push};
    wr_en       = cnt != 2'd0 && !fifo_full;
  end
  always_ff @(posedge wclk or negedge rst_)
    if (!rst_) begin
      state_q     <= EXP_L;
      fs_pair_q   <= f16bits;
      lpend_v_q   <= 1'b0;
      lpend_q     <= '0;
      err_order_q <= 1'b0;
      pair_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fs_pair_q   <= fs_pair_d;
      lpend_v_q   <= lpend_v_d;
      lpend_q     <= lpend_d;
      err_order_q <= err_order_d;
      pair_cnt_q  <= pair_cnt_d;
    end
  pair_buf #(.WIDTH(WIDTH)) u_buf (
    .wclk (wclk),
    .rst_ (rst_),
    .push (push),
    .pop  (wr_en),
    .a    (lpend_q),
    .b    (fmt(s_data, fs_pair_q)),
    .cnt  (cnt),
    .head (din)
  );
  assign err_order = err_order_q;
  assign pair_cnt  = pair_cnt_q;
endmodule

// File: tb/tb_tx_sample_feeder.sv
// tb_tx_sample_feeder: scoreboard bench for tx_sample_feeder
module tb_tx_sample_feeder;
  import tx_sample_feeder_pkg::*;
  localparam int WIDTH = 32;
  localparam int CNT_W = 8;
  logic wclk = 0, rst_ = 0, en = 0, s_valid = 0, fifo_full = 0, err_clr = 0;
  OP_t op = '{frame_size: f16bits};
  chan_t s_chan = CH_L;
  logic [WIDTH-1:0] s_data = '0;
  logic s_ready, wr_en, err_order;
  logic [WIDTH-1:0] din;
  logic [CNT_W-1:0] pair_cnt;
  int checks = 0, failures = 0;
  logic [WIDTH-1:0] q[$];
  logic have_l = 0, m_err = 0;
  logic [WIDTH-1:0] l_word = '0;
  frame_size_t fs_pair = f16bits;
  logic [CNT_W-1:0] m_cnt = '0;

  tx_sample_feeder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .wclk(wclk), .rst_(rst_), .en(en), .OP(op), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_chan(s_chan), .fifo_full(fifo_full), .wr_en(wr_en), .din(din),
    .err_order(err_order), .err_clr(err_clr), .pair_cnt(pair_cnt)
  );

  always #5 wclk = ~wclk;

  function automatic logic [WIDTH-1:0] fmt(input logic [WIDTH-1:0] d, input frame_size_t fs);
    return fs == f16bits ? (d & 32'h0000_FFFF) : d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model + scoreboard, evaluated mid-cycle for the coming edge
  always @(negedge wclk) begin
    logic exp_wr, exp_rdy, xfer, bad;
    if (!rst_) begin
      q.delete();
      have_l = 0;
      m_err = 0;
      m_cnt = '0;
      chk("reset_wr_en", 64'(wr_en), 64'(0));
      chk("reset_din", 64'(din), 64'(0));
      chk("reset_s_ready", 64'(s_ready), 64'(0));
      chk("reset_err_order", 64'(err_order), 64'(0));
      chk("reset_pair_cnt", 64'(pair_cnt), 64'(0));
    end else begin
      exp_wr  = q.size() != 0 && !fifo_full;
      exp_rdy = en && (!have_l || q.size() == 0);
      chk("wr_en", 64'(wr_en), 64'(exp_wr));
      chk("s_ready", 64'(s_ready), 64'(exp_rdy));
      chk("err_order", 64'(err_order), 64'(m_err));
      chk("pair_cnt", 64'(pair_cnt), 64'(m_cnt));
      if (exp_wr && q.size() != 0) begin
        chk("din", 64'(din), 64'(q[0]));
        void'(q.pop_front());
      end
      xfer = s_valid && exp_rdy;
      bad  = xfer && ((s_chan == CH_L) == have_l);
      if (bad) m_err = 1;
      else if (err_clr) m_err = 0;
      if (!en) have_l = 0;
      else if (xfer && !bad) begin
        if (!have_l) begin
          l_word  = fmt(s_data, op.frame_size);
          fs_pair = op.frame_size;
          have_l  = 1;
        end else begin
          q.push_back(l_word);
          q.push_back(fmt(s_data, fs_pair));
          m_cnt++;
          have_l = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic send(input chan_t c, input logic [WIDTH-1:0] d);
    int n = 0;
    s_valid = 1;
    s_chan  = c;
    s_data  = d;
    @(negedge wclk);
    while (!s_ready && n < 100) begin
      n++;
      @(negedge wclk);
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: s_ready stayed %b, required 1", s_ready);
    end
    @(posedge wclk);
    #1;
    s_valid = 0;
  endtask

  task automatic do_reset();
    en = 0;
    rst_ = 0;
    repeat (2) tick();
    rst_ = 1;
    tick();
  endtask

  initial begin
    do_reset();
    en = 1;
    // 1: basic f16 pair
    send(CH_L, 32'hABCD_1234);
    send(CH_R, 32'h0000_5678);
    @(negedge wclk);
    chk("t1_wr_en0", 64'(wr_en), 64'(1));
    chk("t1_din0", 64'(din), 64'(32'h0000_1234));
    @(negedge wclk);
    chk("t1_wr_en1", 64'(wr_en), 64'(1));
    chk("t1_din1", 64'(din), 64'(32'h0000_5678));
    chk("t1_pair_cnt", 64'(pair_cnt), 64'(1));
    tick();
    // 2: order error then recovery
    op.frame_size = f32bits;
    send(CH_R, 32'hDEAD_BEEF);
    @(negedge wclk);
    chk("t2_err_set", 64'(err_order), 64'(1));
    chk("t2_no_wr", 64'(wr_en), 64'(0));
    tick();
    send(CH_L, 32'h1111_2222);
    send(CH_R, 32'h3333_4444);
    repeat (3) tick();
    err_clr = 1;
    tick();
    err_clr = 0;
    @(negedge wclk);
    chk("t2_err_clr", 64'(err_order), 64'(0));
    chk("t2_pair_cnt", 64'(pair_cnt), 64'(2));
    tick();
    // 3: backpressure from a full FIFO
    fifo_full = 1;
    send(CH_L, 32'hA5A5_0001);
    send(CH_R, 32'hA5A5_0002);
    send(CH_L, 32'hA5A5_0003);
    s_valid = 1;
    s_chan = CH_R;
    s_data = 32'hA5A5_0004;
    repeat (10) begin
      @(negedge wclk);
      chk("t3_hold_wr_en", 64'(wr_en), 64'(0));
      chk("t3_hold_s_ready", 64'(s_ready), 64'(0));
      tick();
    end
    fifo_full = 0;
    send(CH_R, 32'hA5A5_0004);
    repeat (4) tick();
    // 4: frame size change mid-pair
    op.frame_size = f16bits;
    send(CH_L, 32'hFFFF_0F0F);
    op.frame_size = f32bits;
    send(CH_R, 32'h1234_5678);
    @(negedge wclk);
    chk("t4_din_l", 64'(din), 64'(32'h0000_0F0F));
    @(negedge wclk);
    chk("t4_din_r", 64'(din), 64'(32'h0000_5678));
    tick();
    // 5: half pair discarded by en=0, buffered pair still drains
    fifo_full = 1;
    send(CH_L, 32'h0BAD_0001);
    send(CH_R, 32'h0BAD_0002);
    send(CH_L, 32'h0BAD_0003);
    en = 0;
    fifo_full = 0;
    repeat (3) tick();
    en = 1;
    send(CH_L, 32'h600D_0001);
    send(CH_R, 32'h600D_0002);
    repeat (4) tick();
    // 6: pair counter wrap, then async reset mid-pair
    do_reset();
    en = 1;
    for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
      op.frame_size = frame_size_t'($urandom_range(0, 1));
      send(CH_L, $urandom);
      send(CH_R, $urandom);
    end
    chk("t6_wrap", 64'(pair_cnt), 64'(1));
    send(CH_L, 32'h7777_8888);
    en = 0;
    rst_ = 0;
    @(negedge wclk);
    chk("t6_rst_din", 64'(din), 64'(0));
    chk("t6_rst_cnt", 64'(pair_cnt), 64'(0));
    tick();
    rst_ = 1;
    en = 1;
    tick();
    // 7: randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 15) != 0;
      s_valid = $urandom_range(0, 1) == 1;
      s_chan = chan_t'($urandom_range(0, 1));
      s_data = $urandom;
      if ($urandom_range(0, 7) == 0) op.frame_size = frame_size_t'($urandom_range(0, 1));
      fifo_full = $urandom_range(0, 3) == 0;
      err_clr = $urandom_range(0, 7) == 0;
      tick();
    end
    en = 1;
    s_valid = 0;
    fifo_full = 0;
    err_clr = 0;
    repeat (6) tick();
    chk("final_drained", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
